load_store_master: RTL
======================

// Module: load_store_master
// PURPOSE
//  Initiator side of the CPU data-memory interface. Takes one load/store command from the
//  MEM stage and runs a req/ack transaction to the word-addressed data memory. For stores it
//  generates byte enables and lane-aligned write data. For loads it does lane extraction and
//  sign/zero extension. Sits between the MEM pipeline stage and the data memory responder.
// PARAMETERS
//  ADDR_W          8   width of memory word index (mem_addr); byte address bits [ADDR_W+1:2] used
//  TIMEOUT_CYCLES  16  max cycles mem_req is held without mem_ack before abort (>=2)
//  CNT_W           5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       command valid; sampled only in IDLE
//  opcode      in   6       0x20 lb,0x21 lh,0x23 lw,0x24 lbu,0x25 lhu,0x28 sb,0x29 sh,0x2B sw
//  address     in   32      byte address (little-endian lanes, lane = address[1:0])
//  store_data  in   32      store operand; byte/half taken from bits [7:0]/[15:0]
//  busy        out  1       high from cycle after accepted start through DONE
//  done        out  1       one-cycle completion pulse
//  err         out  1       one-cycle pulse coincident with done on illegal op/timeout/misalign
//  load_data   out  32      extended load result; updated only on successful load done
//  mem_req     out  1       request; held high until mem_ack or timeout
//  mem_we      out  1       1 = write; stable while mem_req high
//  mem_addr    out  ADDR_W  word index = address[ADDR_W+1:2]; upper bits ignored (wrap)
//  mem_be      out  4       byte enables, bit i = lane i
//  mem_wdata   out  32      lane-aligned store data
//  mem_rdata   in   32      read word, valid in the mem_ack cycle
//  mem_ack     in   1       responder completion; ignored unless mem_req high
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata,
//    load_data = 0; timeout counter = 0. Reset mid-transaction drops mem_req immediately; no done.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
//  - IDLE: start=1 with legal opcode -> latch opcode/lane/data, drive mem_* and go to ACCESS
//    (mem_req high cycle N+1 for start in cycle N). Illegal opcode -> go to DONE with err,
//    no mem_req.
//  - ACCESS: mem_req=1, counter++ each cycle. mem_ack=1 -> on loads capture extended mem_rdata
//    into load_data; drop mem_req; go to DONE. Counter reaching TIMEOUT_CYCLES-1 with no
//    ack -> drop mem_req; go to DONE with err. Ack in that same cycle wins (no err).
//  - DONE: done=1 (err as flagged) for exactly one cycle -> IDLE. Min start-to-done = 2 cycles
//    when ack arrives the first req cycle.
//  - start while busy is ignored (no queueing); start is accepted again in the cycle after done.
//  - Stores: sb be=1<<lane, wdata=byte replicated x4; sh be=lane[1]?1100:0011, wdata=half x2;
//    sw be=1111, wdata=store_data. Loads: be=1111, mem_we=0.
//  - Loads: lb/lh sign-extend the selected byte/half; lbu/lhu zero-extend; lw passes through.
//  - Half lane select uses address[1]; address[0] is handled per CONFIGURATION.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: lh/lhu/sh with address[0]=1, or lw/sw with address[1:0]!=0, are
//    rejected in IDLE. No mem_req. Go to DONE with err=1. load_data is unchanged.
//  MISALIGN_TRAP_EN undefined: misaligned low bits are silently ignored (half uses address[1],
//    word ignores address[1:0]). Access proceeds normally, err never set for misalignment.
// TESTING
//  1 mem word 0x04=0x8899AABB, lb 0x13 -> mem_addr=0x04, be=1111, load_data=0xFFFFFF88, done@+2
//  2 same word: lbu 0x11 -> 0x000000AA; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB
//  3 sb 0x12 data 0x123456CC -> mem_we=1, be=0100, wdata=0xCCCCCCCC; sh 0x12 -> be=1100
//  4 lw 0x10, ack withheld -> mem_req high 16 cycles, then done+err, load_data unchanged
//  5 lw 0x11 -> with MISALIGN_TRAP_EN: done+err, mem_req never high; without: reads word 0x04
//  6 opcode 0x2A -> done+err, no mem_req; rst pulse mid-ACCESS -> mem_req=0 async, no done

Source files
------------

// File: rtl/load_store_master_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_master_if
// Purpose  : Word-addressed req/ack data-memory bus between the load/store
//            master and the data memory responder.
// Revision : 1.0
// ============================================================================
interface load_store_master_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/load_store_master.sv
`default_nettype none
// ============================================================================
// Module   : load_store_master
// Purpose  : MEM-stage load/store initiator: one req/ack word access per
//            command with byte-lane steering and load extension.
//            Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module load_store_master #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [5:0]                 opcode_i,
    input  logic [31:0]                address_i,
    input  logic [31:0]                store_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [31:0]                load_data_o,
    load_store_master_if.master        mem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0]       c_SZ_B     = 2'd0;
    localparam logic [1:0]       c_SZ_H     = 2'd1;
    localparam logic [1:0]       c_SZ_W     = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       load_data_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [1:0]        lane_q;

    logic              w_legal;
    logic              w_store;
    logic              w_unsigned;
    logic [1:0]        w_size;
    logic              w_misalign;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       w_shifted;
    logic [31:0]       load_ext_d;
    logic              w_unused;

    // Byte-address bits above the word index wrap and are intentionally dropped.
    assign w_unused = ^address_i[31:ADDR_W+2];

    always_comb begin
        w_legal    = 1'b1;
        w_store    = 1'b0;
        w_unsigned = 1'b0;
        w_size     = c_SZ_W;
        case (opcode_i)
            6'h20: w_size = c_SZ_B;
            6'h21: w_size = c_SZ_H;
            6'h23: w_size = c_SZ_W;
            6'h24: begin w_size = c_SZ_B; w_unsigned = 1'b1; end
            6'h25: begin w_size = c_SZ_H; w_unsigned = 1'b1; end
            6'h28: begin w_size = c_SZ_B; w_store    = 1'b1; end
            6'h29: begin w_size = c_SZ_H; w_store    = 1'b1; end
            6'h2B: begin w_size = c_SZ_W; w_store    = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == c_SZ_H) && address_i[0]) ||
                        ((w_size == c_SZ_W) && (address_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
        if (w_store) begin
            case (w_size)
                c_SZ_B: begin
                    be_d    = 4'b0001 << address_i[1:0];
                    wdata_d = {4{store_data_i[7:0]}};
                end
                c_SZ_H: begin
                    be_d    = address_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{store_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Bring the addressed lane down to bit 0, then extend from there.
    always_comb begin
        w_shifted  = mem.mem_rdata;
        load_ext_d = mem.mem_rdata;
        case (size_q)
            c_SZ_B: begin
                w_shifted  = mem.mem_rdata >> {lane_q, 3'b000};
                load_ext_d = unsigned_q ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            c_SZ_H: begin
                w_shifted  = mem.mem_rdata >> {lane_q[1], 4'b0000};
                load_ext_d = unsigned_q ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            size_q      <= c_SZ_W;
            unsigned_q  <= 1'b0;
            lane_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (!w_legal || w_misalign) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            req_q      <= 1'b1;
                            we_q       <= w_store;
                            addr_q     <= address_i[ADDR_W+1:2];
                            be_q       <= be_d;
                            wdata_q    <= wdata_d;
                            cnt_q      <= '0;
                            size_q     <= w_size;
                            unsigned_q <= w_unsigned;
                            lane_q     <= address_i[1:0];
                            state_q    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final timeout cycle still completes cleanly.
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                        if (!we_q) begin
                            load_data_q <= load_ext_d;
                        end
                    end else if (cnt_q == c_CNT_LAST) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign load_data_o   = load_data_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule
`default_nettype wire
